riscv_tag_store_unit: RTL and testbench

EX-stage DIFT consumer of the store enable decode. For each store it computes the tag written alongside the data from the rs1 (address) and rs2 (source) tags, gated by the per-operand enables. It also optionally checks the address tag and raises a tag exception. It then issues a single-beat write to the tag memory over a req/gnt/rvalid handshake, stalling the pipeline while the write is outstanding.

---
 rtl/riscv_tag_store_unit_if.sv | 36 +++
 rtl/riscv_tag_store_unit.sv | 100 ++++++++++
 tb/tb_riscv_tag_store_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_tag_store_unit_if.sv
// Tag-memory write bus between the DIFT store unit (master) and the tag memory (slave).
// Single-beat writes: req is held until gnt; completion is signalled by rvalid.
//   req    - write request, held stable until granted
//   gnt    - request accepted by the tag memory
//   rvalid - write completed
//   addr   - 30-bit word address
//   we     - write enable (always 1 alongside req)
//   wdata  - tag to write
interface riscv_tag_store_unit_if #(
  parameter int unsigned TAG_WIDTH = 1
);
  logic                 req;
  logic                 gnt;
  logic                 rvalid;
  logic [29:0]          addr;
  logic                 we;
  logic [TAG_WIDTH-1:0] wdata;

  modport master (
    output req,
    output addr,
    output we,
    output wdata,
    input  gnt,
    input  rvalid
  );

  modport slave (
    input  req,
    input  addr,
    input  we,
    input  wdata,
    output gnt,
    output rvalid
  );
endinterface

// File: rtl/riscv_tag_store_unit.sv
// EX-stage DIFT store unit. Computes the tag stored alongside each store from the rs1/rs2
// tags and their propagation enables, then writes it to tag memory through a
// req/gnt/rvalid handshake, stalling EX (ready=0) while the write is outstanding.
// Optional feature macro: DIFT_TAG_CHECK_EN enables the tainted-address check, which
// suppresses the write and pulses tag_exc for one cycle.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   valid, is_store     - EX instruction valid / is a store
//   enable_a, enable_b  - propagate rs1 / rs2 tag into the stored tag
//   tag_a, tag_b        - rs1 / rs2 tags
//   data_addr           - effective store address
//   check_addr          - trap on tainted store address
//   ready               - unit accepts a store this cycle (0 stalls EX)
//   tag_exc             - one-cycle tag exception pulse
//   mem                 - tag-memory write bus (master side)
module riscv_tag_store_unit #(
  parameter int unsigned TAG_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  is_store,
  input  logic                  enable_a,
  input  logic                  enable_b,
  input  logic [TAG_WIDTH-1:0]  tag_a,
  input  logic [TAG_WIDTH-1:0]  tag_b,
  input  logic [31:0]           data_addr,
  input  logic                  check_addr,
  output logic                  ready,
  output logic                  tag_exc,
  riscv_tag_store_unit_if.master mem
);

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;

  state_e               state_q;
  logic [29:0]          addr_q;
  logic [TAG_WIDTH-1:0] wdata_q;
  logic                 fire;
  logic                 violation;
  logic [TAG_WIDTH-1:0] tag_next;

  // Byte offset is irrelevant for word-granular tags.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = data_addr[1:0];

  // A completing write frees the unit in the same cycle, so back-to-back stores add no bubble.
  assign ready    = (state_q == StIdle) | ((state_q == StWaitRvalid) & mem.rvalid);
  assign fire     = valid & is_store & ready;
  assign tag_next = ({TAG_WIDTH{enable_a}} & tag_a) | ({TAG_WIDTH{enable_b}} & tag_b);

`ifdef DIFT_TAG_CHECK_EN
  logic exc_q;
  assign violation = check_addr & enable_a & (|tag_a);
  assign tag_exc   = exc_q;
`else
  logic unused_check_addr;
  assign unused_check_addr = check_addr;
  assign violation         = 1'b0;
  assign tag_exc           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DIFT_TAG_CHECK_EN
      exc_q   <= 1'b0;
`endif
    end else begin
`ifdef DIFT_TAG_CHECK_EN
      exc_q <= fire & violation;
`endif
      if (fire) begin
        addr_q  <= data_addr[31:2];
        wdata_q <= tag_next;
      end
      unique case (state_q)
        StIdle: begin
          if (fire && !violation) state_q <= StWaitGnt;
        end
        StWaitGnt: begin
          if (mem.gnt) state_q <= StWaitRvalid;
        end
        StWaitRvalid: begin
          if (mem.rvalid) state_q <= (fire && !violation) ? StWaitGnt : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request is a pure decode of registered state, so it is glitch-free and held until grant.
  assign mem.req   = (state_q == StWaitGnt);
  assign mem.we    = (state_q == StWaitGnt);
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_riscv_tag_store_unit.sv
module tb_riscv_tag_store_unit;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, is_store, enable_a, enable_b, check_addr;
  logic [TW-1:0] tag_a, tag_b;
  logic [31:0]   data_addr;
  logic          ready, tag_exc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_tag_store_unit_if #(.TAG_WIDTH(TW)) mem_if ();

  riscv_tag_store_unit #(.TAG_WIDTH(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .is_store   (is_store),
    .enable_a   (enable_a),
    .enable_b   (enable_b),
    .tag_a      (tag_a),
    .tag_b      (tag_b),
    .data_addr  (data_addr),
    .check_addr (check_addr),
    .ready      (ready),
    .tag_exc    (tag_exc),
    .mem        (mem_if.master)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model + scoreboard of expected tag-memory writes.
  typedef struct packed {
    logic [29:0]   addr;
    logic [TW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   m_st  = 0;   // 0 idle, 1 wait gnt, 2 wait rvalid
  logic m_exc = 1'b0;

  always @(negedge clk) begin
    logic          m_ready, m_fire, m_viol;
    logic [TW-1:0] m_tag;
    wr_t           w;
    if (rst) begin
      m_st  = 0;
      m_exc = 1'b0;
      exp_q.delete();
    end else begin
      m_ready = (m_st == 0) || (m_st == 2 && mem_if.rvalid);
      check("mon_ready", ready, m_ready);
      check("mon_req", mem_if.req, m_st == 1);
      check("mon_we", mem_if.we, m_st == 1);
      check("mon_exc", tag_exc, m_exc);
      if (m_st == 1) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_req", 1, 0);
        end else begin
          check("mon_addr", mem_if.addr, exp_q[0].addr);
          check("mon_wdata", mem_if.wdata, exp_q[0].data);
        end
      end
      m_fire = valid && is_store && m_ready;
      m_tag  = (enable_a ? tag_a : '0) | (enable_b ? tag_b : '0);
`ifdef DIFT_TAG_CHECK_EN
      m_viol = check_addr && enable_a && (tag_a != '0);
`else
      m_viol = 1'b0;
`endif
      m_exc = m_fire && m_viol;
      case (m_st)
        0: if (m_fire && !m_viol) m_st = 1;
        1: if (mem_if.gnt) begin
             m_st = 2;
             if (exp_q.size() > 0) void'(exp_q.pop_front());
           end
        2: if (mem_if.rvalid) m_st = (m_fire && !m_viol) ? 1 : 0;
        default: m_st = 0;
      endcase
      if (m_fire && !m_viol) begin
        w.addr = data_addr[31:2];
        w.data = m_tag;
        exp_q.push_back(w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; is_store = 0; enable_a = 0; enable_b = 0;
    tag_a = '0; tag_b = '0; check_addr = 0;
  endtask

  task automatic drive_store(input logic ea, input logic eb, input logic [TW-1:0] ta,
                             input logic [TW-1:0] tb, input logic [31:0] addr, input logic chk);
    valid = 1; is_store = 1; enable_a = ea; enable_b = eb;
    tag_a = ta; tag_b = tb; data_addr = addr; check_addr = chk;
  endtask

  // Full store: accept, optional grant delay, grant, completion. Returns wdata seen at grant.
  task automatic run_store(input logic ea, input logic eb, input logic [TW-1:0] ta,
                           input logic [TW-1:0] tb, input logic [31:0] addr, input int gd,
                           output logic [TW-1:0] wd);
    drive_store(ea, eb, ta, tb, addr, 1'b0);
    tick();
    idle_inputs();
    repeat (gd) tick();
    wd = mem_if.wdata;
    mem_if.gnt = 1;
    tick();
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    tick();
    mem_if.rvalid = 0;
  endtask

  logic [TW-1:0] wd;

  initial begin
    idle_inputs();
    data_addr = '0;
    mem_if.gnt = 0;
    mem_if.rvalid = 0;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();

    check("rst_ready", ready, 1);
    check("rst_req", mem_if.req, 0);
    check("rst_we", mem_if.we, 0);
    check("rst_addr", mem_if.addr, 0);
    check("rst_wdata", mem_if.wdata, 0);
    check("rst_exc", tag_exc, 0);

    // Basic store, rs1 tag propagated.
    drive_store(1, 0, 2'd1, 2'd0, 32'h1000_0008, 0);
    tick();
    idle_inputs();
    check("t1_req", mem_if.req, 1);
    check("t1_addr", mem_if.addr, 30'h0400_0002);
    check("t1_wdata", mem_if.wdata, 1);
    check("t1_ready_busy", ready, 0);
    mem_if.gnt = 1;
    tick();
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    #1 check("t1_ready_done", ready, 1);
    tick();
    mem_if.rvalid = 0;

    // Enable gating of the operand tags.
    run_store(0, 1, 2'd1, 2'd0, 32'h2000_0010, 0, wd);
    check("t2_b_only_zero", wd, 0);
    run_store(0, 1, 2'd1, 2'd1, 32'h2000_0014, 0, wd);
    check("t2_b_only_one", wd, 1);
    run_store(1, 1, 2'd2, 2'd1, 32'h2000_0018, 0, wd);
    check("t2_both_or", wd, 3);
    run_store(0, 0, 2'd3, 2'd3, 32'h2000_001c, 0, wd);
    check("t2_none", wd, 0);

    // Grant delayed 3 cycles: request held stable for 4 cycles.
    drive_store(0, 1, 2'd0, 2'd2, 32'h3000_0100, 0);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check("t3_req", mem_if.req, 1);
      check("t3_addr", mem_if.addr, 30'h0C00_0040);
      check("t3_wdata", mem_if.wdata, 2);
      check("t3_ready", ready, 0);
      if (i == 3) mem_if.gnt = 1;
      tick();
    end
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    tick();
    mem_if.rvalid = 0;

    // Second store presented in the rvalid cycle.
    drive_store(1, 0, 2'd1, 2'd0, 32'h4000_0000, 0);
    tick();
    idle_inputs();
    mem_if.gnt = 1;
    tick();
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    drive_store(0, 1, 2'd0, 2'd3, 32'h4000_0044, 0);
    #1 check("t4_ready_rvalid", ready, 1);
    tick();
    idle_inputs();
    mem_if.rvalid = 0;
    check("t4_req_again", mem_if.req, 1);
    check("t4_new_addr", mem_if.addr, 30'h1000_0011);
    check("t4_new_wdata", mem_if.wdata, 3);
    mem_if.gnt = 1;
    tick();
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    tick();
    mem_if.rvalid = 0;

    // Tainted store address with check enabled.
    drive_store(1, 0, 2'd1, 2'd0, 32'h5000_0004, 1);
    tick();
    idle_inputs();
`ifdef DIFT_TAG_CHECK_EN
    check("t5_exc", tag_exc, 1);
    check("t5_no_req", mem_if.req, 0);
    check("t5_ready", ready, 1);
    tick();
    check("t5_exc_clear", tag_exc, 0);
    check("t5_no_req2", mem_if.req, 0);
`else
    check("t5_exc_off", tag_exc, 0);
    check("t5_req_issued", mem_if.req, 1);
    check("t5_addr", mem_if.addr, 30'h1400_0001);
    mem_if.gnt = 1;
    tick();
    mem_if.gnt = 0;
    mem_if.rvalid = 1;
    tick();
    mem_if.rvalid = 0;
`endif

    // Reset while waiting for grant, then a stray rvalid.
    drive_store(0, 1, 2'd0, 2'd1, 32'h6000_0008, 0);
    tick();
    idle_inputs();
    check("t6_req_before", mem_if.req, 1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_req_after_rst", mem_if.req, 0);
    check("t6_ready_after_rst", ready, 1);
    mem_if.rvalid = 1;
    tick();
    mem_if.rvalid = 0;
    check("t6_stray_rvalid_req", mem_if.req, 0);
    check("t6_stray_rvalid_ready", ready, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
